// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master round-robin Wishbone arbiter:
// FSM state encoding and watchdog counter sizing.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int WDOG_CNT_W      = $clog2(TIMEOUT_DEFAULT + 1);

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_arb_wdog.sv
// Bus watchdog: counts stalled strobe cycles and flags expiry for one cycle
// when the count reaches TIMEOUT. Only instantiated under WB_ARB_TIMEOUT_EN.
module wb_arb_wdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = WDOG_CNT_W
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q == CNT_W'(TIMEOUT));

    // Expiry restarts the count so a still-hung slave is reported again later.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_arb_rr.sv
// Two-master round-robin Wishbone arbiter with lock-preserving grants.
// Define WB_ARB_TIMEOUT_EN to compile in the bus watchdog (wb_arb_wdog).
module wb_arb_rr
    import wb_arb_pkg::*;
#(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    output logic [DAT_W-1:0]   m0_dat_o,
    input  logic [DAT_W/8-1:0] m0_sel_i,
    input  logic               m0_we_i,
    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    output logic               m0_rty_o,
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    output logic [DAT_W-1:0]   m1_dat_o,
    input  logic [DAT_W/8-1:0] m1_sel_i,
    input  logic               m1_we_i,
    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic               m1_rty_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    output logic [DAT_W/8-1:0] s_sel_o,
    output logic               s_we_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    input  logic [DAT_W-1:0]   s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_err_i,
    input  logic               s_rty_i,
    output logic [1:0]         gnt_o
);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_arb_rr: TIMEOUT must be in 2..65535");
    end

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       rst_sync_q;
    logic       own0, own1, mcyc, mstb, timeout;

    // Release of rst_n_i is retimed so the FSM leaves reset on a clock edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
            GNT1: if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
        if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else if (!rst_sync_q) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign own0  = (state_q == GNT0);
    assign own1  = (state_q == GNT1);
    assign gnt_o = {own1, own0};
    assign mcyc  = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
    assign mstb  = (own0 & m0_stb_i) | (own1 & m1_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
    logic busy, term_any;

    assign busy     = mcyc & mstb;
    assign term_any = s_ack_i | s_err_i | s_rty_i;

    wb_arb_wdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (cnt_width(TIMEOUT))
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .inc_i    (busy & ~term_any),
        .clr_i    (term_any | (state_d != state_q) | ~rst_sync_q),
        .expire_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    assign s_cyc_o = mcyc & ~timeout;
    assign s_stb_o = mstb & s_cyc_o;

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        if (own0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
        end else if (own1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
        end
    end

    // A watchdog expiry replaces whatever the slave reports with an error.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = own0 & s_ack_i & ~timeout;
    assign m0_err_o = own0 & (s_err_i | timeout);
    assign m0_rty_o = own0 & s_rty_i & ~timeout;
    assign m1_ack_o = own1 & s_ack_i & ~timeout;
    assign m1_err_o = own1 & (s_err_i | timeout);
    assign m1_rty_o = own1 & s_rty_i & ~timeout;

endmodule

// File: doc/wb_arb_rr.md
WB_ARB_RR -- requirements
Module: wb_arb_rr

Interface
REQ-001 SHALL have parameter ADR_W, default 32: Wishbone address width.
REQ-002 SHALL have parameter DAT_W, default 32: data width; SEL width is DAT_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255: watchdog limit in cycles; legal range 2..65535.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n_i, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have ports m0_adr_i and m1_adr_i, input, ADR_W: master addresses.
REQ-007 SHALL have ports m0_dat_i and m1_dat_i, input, DAT_W: master write data.
REQ-008 SHALL have ports m0_dat_o and m1_dat_o, output, DAT_W: read data, both equal to s_dat_i.
REQ-009 SHALL have ports m0_sel_i and m1_sel_i, input, DAT_W/8: byte selects.
REQ-010 SHALL have ports m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i and m1_stb_i, input, 1: master controls.
REQ-011 SHALL have ports m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o and m1_rty_o, output, 1: master terminations.
REQ-012 SHALL have ports s_adr_o (ADR_W), s_dat_o (DAT_W) and s_sel_o (DAT_W/8), output: slave address, write data and byte selects.
REQ-013 SHALL have ports s_we_o, s_cyc_o and s_stb_o, output, 1: slave controls.
REQ-014 SHALL have port s_dat_i, input, DAT_W: slave read data.
REQ-015 SHALL have ports s_ack_i, s_err_i and s_rty_i, input, 1: slave terminations.
REQ-016 SHALL have port gnt_o, output, 2: one-hot current grant; 2'b00 when idle.

Function
REQ-017 SHALL implement an FSM with states IDLE, GNT0 and GNT1, held in a registered state register.
REQ-018 IDLE: SHALL go to GNT0 if only m0_cyc_i is high, to GNT1 if only m1_cyc_i is high, and to GNT(~last) if both are high.
REQ-019 In GNTx with mx_cyc_i high: SHALL hold the grant, so lock and bursts are never broken.
REQ-020 In GNTx with mx_cyc_i low: SHALL go directly to GNT(other) if the other cyc is high, else to IDLE.
REQ-021 SHALL update the `last` register to x on every entry into GNTx.
REQ-022 Grant latency SHALL be one cycle from a request in IDLE to s_cyc_o high.
REQ-023 Handover latency SHALL be zero dead cycles beyond the edge at which the current cyc drops.
REQ-024 s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o and s_stb_o SHALL be combinational muxes of the granted master.
REQ-025 In IDLE, s_cyc_o and s_stb_o SHALL be 0 and the slave data, address, select and we outputs SHALL be 0.
REQ-026 s_ack_i, s_err_i and s_rty_i SHALL be forwarded combinationally to the granted master only.
REQ-027 The non-granted master SHALL see ack, err and rty equal to 0.
REQ-028 s_stb_o SHALL be qualified with s_cyc_o, so stb without cyc never reaches the slave.
REQ-029 A termination arriving in the same cycle as a grant switch SHALL go to the master granted in that cycle, which is the previous owner.

Reset
REQ-030 While rst_n_i is low: state=IDLE, last=1 (so m0 wins the first tie), gnt_o=0, watchdog counter=0, and all slave and master control outputs=0.
REQ-031 Reset asserted mid-transfer SHALL abort without any termination to either master.
REQ-032 Deassertion SHALL be synchronous to clk_i; the first grant is possible on the second rising edge after release.

Configuration
REQ-033 SHALL provide macro WB_ARB_TIMEOUT_EN, which compiles the bus watchdog in or out.
REQ-034 When WB_ARB_TIMEOUT_EN is defined, the counter SHALL increment while s_cyc_o && s_stb_o && !(s_ack_i|s_err_i|s_rty_i).
REQ-035 When WB_ARB_TIMEOUT_EN is defined, the counter SHALL clear on any termination or grant change.
REQ-036 When WB_ARB_TIMEOUT_EN is defined and the counter reaches TIMEOUT, the arbiter SHALL assert mx_err_o to the owner for exactly one cycle.
REQ-037 In that timeout cycle, s_cyc_o and s_stb_o SHALL be forced to 0 and the counter SHALL clear.
REQ-038 When WB_ARB_TIMEOUT_EN is not defined, there SHALL be no counter logic, and a hung slave holds the grant indefinitely.

Structure
REQ-039 Package wb_arb_pkg SHALL hold the state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the localparam for the counter width, $clog2(TIMEOUT+1).
REQ-040 The watchdog SHALL be sub-module wb_arb_wdog (count/clear/expire), instantiated only under WB_ARB_TIMEOUT_EN.
REQ-041 There SHALL be no other sub-modules.

Verification
REQ-042 Reset release, then m0_cyc=m1_cyc=1 simultaneously -> gnt_o=01 one cycle later; after m0 drops cyc -> gnt_o=10 on the next edge.
REQ-043 Both masters continuously requesting with single-beat cycles, 10 transfers -> grants alternate m0,m1,m0,… and each master receives 5 acks.
REQ-044 m1 holds cyc for a 4-beat burst while m0 requests -> m0 is never granted until m1 drops cyc, and m0_ack_o stays 0 throughout.
REQ-045 m0 reads 0x40000010 while the slave returns 0xDEADBEEF with ack -> m0_dat_o=0xDEADBEEF, m0_ack_o pulses one cycle, and m1_ack_o=0.
REQ-046 With WB_ARB_TIMEOUT_EN and TIMEOUT=8, a slave that never acks -> m0_err_o pulses exactly one cycle at cycle 8 after stb, and s_cyc_o=0 in that cycle; without the macro, no err occurs.
REQ-047 rst_n_i pulled low during an active m1 transfer -> gnt_o=00, s_cyc_o=0 immediately, and no ack, err or rty is issued.
